// File: rtl/uart_ctl_p_pkg.sv
// Shared definitions for the parametrised UART controller:
// FSM states, parity codes, oversampling ratio and parity helper.
package uart_ctl_p_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } uart_st_t;

    function automatic logic par_bit(input logic [7:0] d, input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_ctl_p_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_ctl_p_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int D = 1 << AW;

    logic [W-1:0] mem [D];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(D));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rp];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/uart_ctl_p.sv
// Full-duplex UART with internal 16x oversampling tick, configurable
// frame format and TX/RX FIFOs.
module uart_ctl_p
    import uart_ctl_p_pkg::*;
#(
    parameter int OSR_DIV   = 27,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [7:0] din,
    input  logic       tx_en,
    input  logic       rd_en,
    output logic       tx,
    output logic [7:0] dout,
    output logic       d_rdy,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_ovr
);

    localparam int         DW      = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
    localparam logic [7:0] DMASK   = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0] LAST    = 3'(DATA_BITS - 1);
    localparam logic [3:0] TMAX    = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TMID    = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [1:0] PMODE   = 2'(PARITY);
    localparam logic       HAS_PAR = (PMODE != PAR_NONE);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $error("uart_ctl_p: illegal frame parameters");
    end

    logic [DW-1:0] div_q;
    logic          tick;
    logic          realign;

    assign tick = (div_q == DW'(OSR_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst || realign || tick) div_q <= '0;
        else                         div_q <= div_q + 1'b1;
    end

    logic rs1, rs2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rs1 <= 1'b1;
            rs2 <= 1'b1;
        end else begin
            rs1 <= rx;
            rs2 <= rs1;
        end
    end

    // ---------------- receiver ----------------
    uart_st_t   rx_st, rx_nx;
    logic [3:0] rx_tk, rtk_n;
    logic [2:0] rx_bit, rbit_n;
    logic [7:0] rx_sh, rsh_n;
    logic       rx_pb, rpb_n;
    logic       rx_push, rx_pop, rxf_full, rxf_empty;
    logic       ferr_d, perr_d, ovr_d;

    assign rx_pop = rd_en && !rxf_empty;

    always_comb begin
        rx_nx   = rx_st;
        rtk_n   = rx_tk;
        rbit_n  = rx_bit;
        rsh_n   = rx_sh;
        rpb_n   = rx_pb;
        rx_push = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
        ovr_d   = 1'b0;
        unique case (rx_st)
            S_IDLE: if (!rs2) begin
                rx_nx = S_START;
                rtk_n = '0;
            end
            S_START: if (tick) begin
                rtk_n = rx_tk + 4'd1;
                if (rx_tk == TMID) begin
                    rtk_n  = '0;
                    rbit_n = '0;
                    rsh_n  = '0;
                    rx_nx  = rs2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: if (tick) begin
                rtk_n = rx_tk + 4'd1;
                if (rx_tk == TMAX) begin
                    rsh_n       = rx_sh >> 1;
                    rsh_n[LAST] = rs2;
                    rbit_n      = rx_bit + 3'd1;
                    if (rx_bit == LAST) rx_nx = HAS_PAR ? S_PAR : S_STOP;
                end
            end
            S_PAR: if (tick) begin
                rtk_n = rx_tk + 4'd1;
                if (rx_tk == TMAX) begin
                    rpb_n = rs2;
                    rx_nx = S_STOP;
                end
            end
            S_STOP: if (tick) begin
                rtk_n = rx_tk + 4'd1;
                if (rx_tk == TMAX) begin
                    ferr_d = !rs2;
                    perr_d = HAS_PAR && (rx_pb != par_bit(rx_sh, PMODE));
                    if (!ferr_d && !perr_d) begin
                        if (rxf_full && !rx_pop) ovr_d   = 1'b1;
                        else                     rx_push = 1'b1;
                    end
                    rx_nx = S_IDLE;
                end
            end
            default: rx_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_st      <= S_IDLE;
            rx_tk      <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_pb      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            rx_ovr     <= 1'b0;
        end else begin
            rx_st      <= rx_nx;
            rx_tk      <= rtk_n;
            rx_bit     <= rbit_n;
            rx_sh      <= rsh_n;
            rx_pb      <= rpb_n;
            frame_err  <= ferr_d;
            parity_err <= perr_d;
            rx_ovr     <= ovr_d;
        end
    end

    uart_ctl_p_fifo #(.W(8), .AW(FIFO_AW)) u_rxf (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_sh),
        .dout  (dout),
        .full  (rxf_full),
        .empty (rxf_empty)
    );

    assign d_rdy = !rxf_empty;

    // ---------------- transmitter ----------------
    uart_st_t   tx_st, tx_nx;
    logic [3:0] tx_tk, ttk_n;
    logic [2:0] tx_bit, tbit_n;
    logic [7:0] tx_sh, tsh_n;
    logic       tx_par, tpar_n;
    logic       tx_stp, tstp_n;
    logic       tx_q, tx_d;
    logic       tx_pop, txf_empty;
    logic [7:0] txf_dout;

    always_comb begin
        tx_nx   = tx_st;
        ttk_n   = tx_tk;
        tbit_n  = tx_bit;
        tsh_n   = tx_sh;
        tpar_n  = tx_par;
        tstp_n  = tx_stp;
        tx_d    = tx_q;
        tx_pop  = 1'b0;
        realign = 1'b0;
        unique case (tx_st)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!txf_empty) begin
                    tx_pop  = 1'b1;
                    realign = 1'b1;
                    ttk_n   = '0;
                    tsh_n   = txf_dout;
                    tpar_n  = par_bit(txf_dout, PMODE);
                    tx_nx   = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: if (tick) begin
                ttk_n = tx_tk + 4'd1;
                if (tx_tk == TMAX) begin
                    tbit_n = '0;
                    tx_nx  = S_DATA;
                    tx_d   = tx_sh[0];
                end
            end
            S_DATA: if (tick) begin
                ttk_n = tx_tk + 4'd1;
                if (tx_tk == TMAX) begin
                    tsh_n  = tx_sh >> 1;
                    tbit_n = tx_bit + 3'd1;
                    if (tx_bit == LAST) begin
                        tstp_n = 1'b0;
                        tx_nx  = HAS_PAR ? S_PAR : S_STOP;
                        tx_d   = HAS_PAR ? tx_par : 1'b1;
                    end else begin
                        tx_d = tx_sh[1];
                    end
                end
            end
            S_PAR: if (tick) begin
                ttk_n = tx_tk + 4'd1;
                if (tx_tk == TMAX) begin
                    tstp_n = 1'b0;
                    tx_nx  = S_STOP;
                    tx_d   = 1'b1;
                end
            end
            S_STOP: if (tick) begin
                ttk_n = tx_tk + 4'd1;
                if (tx_tk == TMAX) begin
                    if (STOP_BITS == 2 && !tx_stp) begin
                        tstp_n = 1'b1;
                    end else if (!txf_empty) begin
                        // chain the next word with no idle gap
                        tx_pop = 1'b1;
                        tsh_n  = txf_dout;
                        tpar_n = par_bit(txf_dout, PMODE);
                        tx_nx  = S_START;
                        tx_d   = 1'b0;
                    end else begin
                        tx_nx = S_IDLE;
                        tx_d  = 1'b1;
                    end
                end
            end
            default: tx_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_st  <= S_IDLE;
            tx_tk  <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx_par <= 1'b0;
            tx_stp <= 1'b0;
            tx_q   <= 1'b1;
        end else begin
            tx_st  <= tx_nx;
            tx_tk  <= ttk_n;
            tx_bit <= tbit_n;
            tx_sh  <= tsh_n;
            tx_par <= tpar_n;
            tx_stp <= tstp_n;
            tx_q   <= tx_d;
        end
    end

    uart_ctl_p_fifo #(.W(8), .AW(FIFO_AW)) u_txf (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_en),
        .pop   (tx_pop),
        .din   (din & DMASK),
        .dout  (txf_dout),
        .full  (tx_full),
        .empty (txf_empty)
    );

    assign tx      = tx_q;
    assign tx_busy = (tx_st != S_IDLE) || !txf_empty;

endmodule
